// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared state codes and widths for the round-robin 8:1 mux arbiter.
package mux8_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int SEL_W = 3;
  localparam int N_REQ = 8;
  localparam int CNT_W = 5;

endpackage

// File: rtl/mux8_rr_arbiter_mux.sv
// Shared 8:1 single-bit multiplexer, inputs I0..I7 selected by {S2,S1,S0}.
module mux8
  import mux8_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] d,
  input  logic [SEL_W-1:0] s,
  output logic             y
);

  logic [N_REQ-1:0] term;

  for (genvar g = 0; g < N_REQ; g++) begin : g_term
    assign term[g] = d[g] & (s == SEL_W'(g));
  end

  assign y = |term;

endmodule

// File: rtl/mux8_rr_arbiter_pick.sv
// Round-robin picker: rotate req so ptr lands at bit 0, priority encode, rotate back.
module rr_pick8
  import mux8_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] off;

  always_comb begin
    rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[SEL_W'(i) + ptr];
    end
  end

  // Scan downward so the lowest set bit (closest to ptr) wins.
  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  assign idx = off + ptr;
  assign any = |req;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the shared 8:1 mux select, with bursts of up to
// MAX_BURST transfers per grant under a valid/ready handshake.
module mux8_rr_arbiter
  import mux8_rr_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] din,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] grant,
  output logic             out_valid,
  output logic             out_data
);

  state_t           state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n, sel_n, pick_ptr, pick_idx;
  logic [N_REQ-1:0] grant_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             pick_any, mux_y, xfer, last, grant_end;

  // While granting, the picker already looks from sel+1 so a re-pick needs no bubble.
  assign pick_ptr = (state == ST_GRANT) ? sel + SEL_W'(1) : ptr;

  rr_pick8 u_pick (
    .req (req),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  mux8 u_mux (
    .d (din),
    .s (sel),
    .y (mux_y)
  );

  assign out_valid = (state == ST_GRANT) & req[sel];
  assign out_data  = mux_y & out_valid;
  assign xfer      = out_valid & out_ready;
  assign last      = xfer & (cnt == CNT_W'(MAX_BURST - 1));
  assign grant_end = (state == ST_GRANT) & (~req[sel] | last);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel;
    grant_n = grant;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_n = ST_GRANT;
          sel_n   = pick_idx;
          grant_n = N_REQ'(1) << pick_idx;
          cnt_n   = '0;
        end
      end
      ST_GRANT: begin
        if (grant_end) begin
          ptr_n = pick_ptr;
          cnt_n = '0;
          if (pick_any) begin
            sel_n   = pick_idx;
            grant_n = N_REQ'(1) << pick_idx;
          end else begin
            state_n = ST_IDLE;
            grant_n = '0;
          end
        end else if (xfer) begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        grant_n = '0;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= '0;
      sel   <= '0;
      grant <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      sel   <= sel_n;
      grant <= grant_n;
      cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed vector table plus hand sequences for the round-robin mux arbiter.
module tb_mux8_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req, din;
  logic       out_ready;
  logic [2:0] sel;
  logic [7:0] grant;
  logic       out_valid, out_data;

  int checks = 0;
  int failures = 0;

  mux8_rr_arbiter #(.MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .din       (din),
    .out_ready (out_ready),
    .sel       (sel),
    .grant     (grant),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic [7:0] din;
    logic       rdy;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       valid;
    logic       data;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] g, input logic [2:0] s,
                         input logic v, input logic d);
    chk({tag, " grant"}, grant, g);
    chk({tag, " sel"}, {5'd0, sel}, {5'd0, s});
    chk({tag, " out_valid"}, {7'd0, out_valid}, {7'd0, v});
    chk({tag, " out_data"}, {7'd0, out_data}, {7'd0, d});
  endtask

  initial begin
    // req, din, rdy -> grant, sel, valid, data (outputs after the edge, same inputs held)
    vecs[0]  = '{8'h20, 8'h20, 1'b1, 8'h20, 3'd5, 1'b1, 1'b1};
    vecs[1]  = '{8'h20, 8'h20, 1'b1, 8'h20, 3'd5, 1'b1, 1'b1};
    vecs[2]  = '{8'h20, 8'h00, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0};
    vecs[3]  = '{8'h20, 8'h20, 1'b1, 8'h20, 3'd5, 1'b1, 1'b1};
    vecs[4]  = '{8'h20, 8'h20, 1'b1, 8'h20, 3'd5, 1'b1, 1'b1};
    vecs[5]  = '{8'h00, 8'h20, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0};
    vecs[6]  = '{8'h40, 8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 1'b1};
    vecs[7]  = '{8'h40, 8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 1'b1};
    vecs[8]  = '{8'h40, 8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 1'b1};
    vecs[9]  = '{8'h40, 8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 1'b1};
    vecs[10] = '{8'h40, 8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 1'b1};
    vecs[11] = '{8'h40, 8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 1'b1};
    vecs[12] = '{8'h41, 8'h41, 1'b1, 8'h40, 3'd6, 1'b1, 1'b1};
    vecs[13] = '{8'h41, 8'h41, 1'b1, 8'h40, 3'd6, 1'b1, 1'b1};
    vecs[14] = '{8'h41, 8'h41, 1'b1, 8'h40, 3'd6, 1'b1, 1'b1};
    vecs[15] = '{8'h41, 8'h41, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1};
    vecs[16] = '{8'h04, 8'h04, 1'b1, 8'h04, 3'd2, 1'b1, 1'b1};
    vecs[17] = '{8'h85, 8'h00, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0};
    vecs[18] = '{8'h81, 8'h00, 1'b1, 8'h80, 3'd7, 1'b1, 1'b0};

    // Reset state, with requests present to show they are ignored.
    rst_n = 1'b0; req = 8'hFF; din = 8'hFF; out_ready = 1'b1;
    step();
    chk_all("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    req = 8'h00;
    step();
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      req = vecs[i].req; din = vecs[i].din; out_ready = vecs[i].rdy;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].grant, vecs[i].sel, vecs[i].valid, vecs[i].data);
    end

    // Reset mid-burst: requester 3 granted, two transfers done.
    rst_n = 1'b0; req = 8'h00;
    step();
    rst_n = 1'b1; req = 8'h08; din = 8'h08; out_ready = 1'b1;
    step(); step(); step();
    chk("midburst pre grant", grant, 8'h08);
    rst_n = 1'b0;
    step();
    chk_all("midburst reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_all("after reset", 8'h08, 3'd3, 1'b1, 1'b1);

    // Fairness: all requesting, each granted for exactly 4 cycles in order.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; req = 8'hFF; din = 8'hAA; out_ready = 1'b1;
    for (int c = 0; c < 36; c++) begin
      logic [7:0] eg;
      logic [2:0] es;
      step();
      es = 3'((c / 4) % 8);
      eg = 8'h01 << es;
      chk($sformatf("rr c%0d grant", c), grant, eg);
      chk($sformatf("rr c%0d valid", c), {7'd0, out_valid}, 8'h01);
      chk($sformatf("rr c%0d data", c), {7'd0, out_data}, {7'd0, din[es]});
    end

    // Drain: everything drops, arbiter must go idle.
    req = 8'h00;
    step();
    chk("drain grant", grant, 8'h00);
    chk("drain valid", {7'd0, out_valid}, 8'h00);
    chk("drain data", {7'd0, out_data}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
